// File: rtl/lut_gate_bank_if.sv
// rtl/lut_gate_bank_if.sv - configuration port bundle for lut_gate_bank
// Purpose: groups the shadow-write / commit handshake of the LUT bank.
// Signals:
//   cfg_valid  write request            cfg_ready  write/commit accepted (IDLE)
//   cfg_chan   target channel (CW bits)  cfg_lut    truth table, bit index {b,a}
//   cfg_mode   0 logic, 1 toggle         cfg_commit shadow -> active request
//   cfg_err    sticky out-of-range write seen
// Modports: master drives requests, slave (the bank) drives ready/err.
interface lut_gate_bank_if #(
  parameter int CHANNELS = 8
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [3:0]    cfg_lut;
  logic          cfg_mode;
  logic          cfg_commit;
  logic          cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_lut, cfg_mode, cfg_commit,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_lut, cfg_mode, cfg_commit,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/lut_gate_bank.sv
// rtl/lut_gate_bank.sv - bank of runtime-programmable 2-input LUT cells
// Purpose: CHANNELS independent cells, each r = lut[{b,a}], either registered
//   directly (logic mode) or XORed into its own state (toggle mode), followed by
//   PIPE_STAGES output registers. Config is double buffered: writes land in a
//   shadow copy and a commit copies the whole shadow into the active copy.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             datapath advance enable
//   in_a, in_b      per-channel operands
//   cfg             configuration port (lut_gate_bank_if.slave)
//   out, out_valid  pipelined cell outputs, outputs reflect active config
module lut_gate_bank #(
  parameter int         CHANNELS    = 8,
  parameter int         PIPE_STAGES = 1,
  parameter logic [3:0] CFG_DEFAULT = 4'b1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [CHANNELS-1:0] in_a,
  input  logic [CHANNELS-1:0] in_b,
  lut_gate_bank_if.slave      cfg,
  output logic [CHANNELS-1:0] out,
  output logic                out_valid
);
  localparam int            CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [1:0]    LAT    = 2'(1 + PIPE_STAGES);
  localparam logic [CW:0]   CH_LIM = CHANNELS[CW:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_APPLY
  } state_t;

  state_t state_q, state_d;
  logic   load_active;

  logic [3:0]          shd_lut_q [CHANNELS];
  logic [3:0]          shd_lut_d [CHANNELS];
  logic [3:0]          act_lut_q [CHANNELS];
  logic [CHANNELS-1:0] shd_mode_q, shd_mode_d, act_mode_q;

  logic [CHANNELS-1:0] lut_r, cell_d, cell_q;
  logic [1:0]          vcnt_q;
  logic                err_q;
  logic                wr_fire, wr_in_range;

  // ---------------- config FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A commit only takes effect on an enabled cycle so that the flush and the
  // datapath restart line up with a real clock of the cells.
  always_comb begin
    state_d     = state_q;
    load_active = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_commit) begin
          if (ena) begin
            load_active = 1'b1;
            state_d     = ST_APPLY;
          end else begin
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (ena) begin
          load_active = 1'b1;
          state_d     = ST_APPLY;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cfg.cfg_ready = (state_q == ST_IDLE);

  // ---------------- shadow / active config ----------------
  assign wr_fire     = cfg.cfg_valid & cfg.cfg_ready;
  assign wr_in_range = ({1'b0, cfg.cfg_chan} < CH_LIM);

  // Next shadow includes a write accepted this cycle, so a same-cycle
  // write+commit lands in the active copy immediately.
  always_comb begin
    shd_lut_d  = shd_lut_q;
    shd_mode_d = shd_mode_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_fire && wr_in_range && (cfg.cfg_chan == CW'(i))) begin
        shd_lut_d[i]  = cfg.cfg_lut;
        shd_mode_d[i] = cfg.cfg_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shd_lut_q[i] <= CFG_DEFAULT;
        act_lut_q[i] <= CFG_DEFAULT;
      end
      shd_mode_q <= '0;
      act_mode_q <= '0;
    end else begin
      shd_lut_q  <= shd_lut_d;
      shd_mode_q <= shd_mode_d;
      if (load_active) begin
        act_lut_q  <= shd_lut_d;
        act_mode_q <= shd_mode_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_q <= 1'b0;
    else if (wr_fire && !wr_in_range) err_q <= 1'b1;
  end

  assign cfg.cfg_err = err_q;

  // ---------------- cells ----------------
  always_comb begin
    lut_r  = '0;
    cell_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lut_r[i]  = act_lut_q[i][{in_b[i], in_a[i]}];
      cell_d[i] = act_mode_q[i] ? (cell_q[i] ^ lut_r[i]) : lut_r[i];
    end
  end

  // vcnt counts enabled cycles since the last flush, saturating at the
  // pipeline depth; outputs are trustworthy once it gets there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_q <= '0;
      vcnt_q <= '0;
    end else if (load_active) begin
      cell_q <= '0;
      vcnt_q <= '0;
    end else if (ena) begin
      cell_q <= cell_d;
      if (vcnt_q != LAT) vcnt_q <= vcnt_q + 2'd1;
    end
  end

  assign out_valid = (vcnt_q == LAT);

  // ---------------- output pipeline ----------------
  generate
    if (PIPE_STAGES == 0) begin : g_nopipe
      assign out = cell_q;
    end else begin : g_pipe
      logic [CHANNELS-1:0] pipe_q [PIPE_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
        end else if (load_active) begin
          for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
        end else if (ena) begin
          pipe_q[0] <= cell_q;
          for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign out = pipe_q[PIPE_STAGES-1];
    end
  endgenerate
endmodule

// File: tb/tb_lut_gate_bank.sv
// tb/tb_lut_gate_bank.sv - self-checking bench for lut_gate_bank
module tb_lut_gate_bank;
  localparam int CH  = 8;
  localparam int PS  = 1;
  localparam int LAT = PS + 1;
  localparam int CH6 = 6;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena;
  logic [7:0] in_a, in_b;
  logic [7:0] out8;
  logic       valid8;
  logic [5:0] a6, b6;
  logic [5:0] out6;
  logic       valid6;

  lut_gate_bank_if #(.CHANNELS(CH))  cfg_if  ();
  lut_gate_bank_if #(.CHANNELS(CH6)) cfg6_if ();

  lut_gate_bank #(.CHANNELS(CH), .PIPE_STAGES(PS), .CFG_DEFAULT(4'b1000)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_a(in_a), .in_b(in_b),
    .cfg(cfg_if), .out(out8), .out_valid(valid8)
  );

  lut_gate_bank #(.CHANNELS(CH6), .PIPE_STAGES(0), .CFG_DEFAULT(4'b1000)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_a(a6), .in_b(b6),
    .cfg(cfg6_if), .out(out6), .out_valid(valid6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_line[0] is the newest cell value, m_line[LAT-1] is what out shows.
  // m_phase: 0 = accepting, 1 = commit waiting for ena, 2 = settling.
  logic [3:0]    m_sh_lut [CH];
  logic [3:0]    m_ac_lut [CH];
  logic [CH-1:0] m_sh_mode, m_ac_mode;
  logic [7:0]    m_line [$];
  int            m_en_cnt;
  int            m_phase;

  task automatic model_flush();
    m_line = {};
    for (int i = 0; i < LAT; i++) m_line.push_back(8'h00);
    m_en_cnt = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_sh_lut[i] = 4'b1000;
      m_ac_lut[i] = 4'b1000;
    end
    m_sh_mode = '0;
    m_ac_mode = '0;
    m_phase   = 0;
    model_flush();
  endtask

  task automatic model_step();
    logic [7:0] nxt;
    logic [7:0] cur;
    int         idx;
    bit         r;
    bit         load;
    load = 1'b0;
    nxt  = '0;
    if (m_phase == 0 && cfg_if.cfg_valid) begin
      m_sh_lut[cfg_if.cfg_chan]  = cfg_if.cfg_lut;
      m_sh_mode[cfg_if.cfg_chan] = cfg_if.cfg_mode;
    end
    if (m_phase == 0) begin
      if (cfg_if.cfg_commit) begin
        if (ena) begin load = 1'b1; m_phase = 2; end
        else m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ena) begin load = 1'b1; m_phase = 2; end
    end else begin
      m_phase = 0;
    end
    if (load) begin
      m_ac_lut  = m_sh_lut;
      m_ac_mode = m_sh_mode;
      model_flush();
    end else if (ena) begin
      cur = m_line[0];
      for (int i = 0; i < CH; i++) begin
        idx = 2 * int'(in_b[i]) + int'(in_a[i]);
        r   = ((m_ac_lut[i] >> idx) & 4'd1) != 4'd0;
        if (m_ac_mode[i]) nxt[i] = r ? ~cur[i] : cur[i];
        else              nxt[i] = r;
      end
      m_line.push_front(nxt);
      void'(m_line.pop_back());
      m_en_cnt++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_out",   32'(out8),             32'(m_line[LAT-1]));
    chk("model_valid", 32'(valid8),           32'(m_en_cnt >= LAT));
    chk("model_ready", 32'(cfg_if.cfg_ready), 32'(m_phase == 0));
    chk("model_err",   32'(cfg_if.cfg_err),   32'd0);
  endtask

  task automatic idle_cfg();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    cfg_if.cfg_chan   = '0;
    cfg_if.cfg_lut    = '0;
    cfg_if.cfg_mode   = 1'b0;
  endtask

  task automatic wr(input int ch, input logic [3:0] lut, input logic mode, input logic commit);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_chan   = 3'(ch);
    cfg_if.cfg_lut    = lut;
    cfg_if.cfg_mode   = mode;
    cfg_if.cfg_commit = commit;
    tick();
    idle_cfg();
  endtask

  task automatic commit_only();
    cfg_if.cfg_commit = 1'b1;
    tick();
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_out",   32'(out8),              32'h0);
    chk("rst_valid", 32'(valid8),            32'h0);
    chk("rst_ready", 32'(cfg_if.cfg_ready),  32'h1);
    chk("rst_err",   32'(cfg_if.cfg_err),    32'h0);
    chk("rst_err6",  32'(cfg6_if.cfg_err),   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [5];
  logic [3:0] luts [8];
  logic [1:0] tog_exp [4];

  initial begin
    // channels 0..7: AND NAND OR XOR NOTa PASSa NOR XNOR
    luts[0] = 4'b1000; luts[1] = 4'b0111; luts[2] = 4'b1110; luts[3] = 4'b0110;
    luts[4] = 4'b0101; luts[5] = 4'b1010; luts[6] = 4'b0001; luts[7] = 4'b1001;
    vecs[0] = '{8'h00, 8'h00, 8'hD2};
    vecs[1] = '{8'hFF, 8'h00, 8'h2E};
    vecs[2] = '{8'h00, 8'hFF, 8'h1E};
    vecs[3] = '{8'hFF, 8'hFF, 8'hA5};
    vecs[4] = '{8'h55, 8'h33, 8'h87};
    tog_exp[0] = 2'd0; tog_exp[1] = 2'd1; tog_exp[2] = 2'd0; tog_exp[3] = 2'd1;

    ena = 1'b1; in_a = '0; in_b = '0; a6 = '0; b6 = '0;
    idle_cfg();
    cfg6_if.cfg_valid = 1'b0; cfg6_if.cfg_commit = 1'b0; cfg6_if.cfg_chan = '0;
    cfg6_if.cfg_lut = '0; cfg6_if.cfg_mode = 1'b0;
    #1;
    do_reset();

    // reset latency: a=b=FF through default AND
    in_a = 8'hFF; in_b = 8'hFF;
    tick();
    chk("lat_out_e1",   32'(out8),   32'h00);
    chk("lat_valid_e1", 32'(valid8), 32'h0);
    tick();
    chk("lat_out_e2",   32'(out8),   32'hFF);
    chk("lat_valid_e2", 32'(valid8), 32'h1);

    // shadow write is invisible until commit
    in_a = 8'h04; in_b = 8'h00;
    wr(2, 4'b0110, 1'b0, 1'b0);
    tick();
    chk("no_commit_out", 32'(out8), 32'h00);
    commit_only();
    chk("commit_ready0", 32'(cfg_if.cfg_ready), 32'h0);
    chk("commit_flush",  32'(out8),             32'h00);
    tick();
    chk("commit_ready1", 32'(cfg_if.cfg_ready), 32'h1);
    tick();
    chk("xor_out",   32'(out8),   32'h04);
    chk("xor_valid", 32'(valid8), 32'h1);

    // toggle mode on ch0 with a0 held high
    in_a = 8'h05; in_b = 8'h00;
    wr(0, 4'b1010, 1'b1, 1'b0);
    commit_only();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("toggle_%0d", k), 32'(out8[0]), 32'(tog_exp[k]));
    end
    chk("toggle_all", 32'(out8), 32'h05);

    // commit with ena low parks in PENDING
    ena = 1'b0;
    cfg_if.cfg_commit = 1'b1;
    tick();
    cfg_if.cfg_commit = 1'b0;
    chk("pend_ready0", 32'(cfg_if.cfg_ready), 32'h0);
    chk("pend_hold0",  32'(out8),             32'h05);
    tick();
    chk("pend_ready1", 32'(cfg_if.cfg_ready), 32'h0);
    chk("pend_hold1",  32'(out8),             32'h05);
    ena = 1'b1;
    tick();
    chk("apply_ready", 32'(cfg_if.cfg_ready), 32'h0);
    chk("apply_flush", 32'(out8),             32'h00);
    chk("apply_valid", 32'(valid8),           32'h0);
    tick();
    chk("apply_done",  32'(cfg_if.cfg_ready), 32'h1);

    // same-cycle write + commit
    in_a = 8'h00; in_b = 8'h00;
    wr(5, 4'b0111, 1'b0, 1'b1);
    tick();
    tick();
    chk("same_cycle_nand", 32'(out8),   32'h20);
    chk("same_cycle_vld",  32'(valid8), 32'h1);

    // table of mixed functions
    for (int c = 0; c < CH; c++) wr(c, luts[c], 1'b0, (c == CH - 1));
    tick();
    for (int v = 0; v < 5; v++) begin
      in_a = vecs[v].a;
      in_b = vecs[v].b;
      tick();
      tick();
      chk($sformatf("table_%0d", v), 32'(out8), 32'(vecs[v].exp));
    end

    // out-of-range write on the 6-channel bank
    a6 = 6'h3F; b6 = 6'h3F;
    cfg6_if.cfg_valid = 1'b1; cfg6_if.cfg_chan = 3'd7; cfg6_if.cfg_lut = 4'b0111;
    tick();
    cfg6_if.cfg_valid = 1'b0;
    chk("err6_set", 32'(cfg6_if.cfg_err), 32'h1);
    cfg6_if.cfg_commit = 1'b1;
    tick();
    cfg6_if.cfg_commit = 1'b0;
    tick();
    chk("err6_out",    32'(out6),            32'h3F);
    chk("err6_valid",  32'(valid6),          32'h1);
    chk("err6_sticky", 32'(cfg6_if.cfg_err), 32'h1);

    // reset while PENDING discards shadow writes
    in_a = 8'h00; in_b = 8'h00;
    wr(3, 4'b0001, 1'b0, 1'b0);
    ena = 1'b0;
    cfg_if.cfg_commit = 1'b1;
    tick();
    cfg_if.cfg_commit = 1'b0;
    chk("midreset_pend", 32'(cfg_if.cfg_ready), 32'h0);
    do_reset();
    ena = 1'b1;
    commit_only();
    tick();
    tick();
    chk("midreset_out",   32'(out8),   32'h00);
    chk("midreset_valid", 32'(valid8), 32'h1);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      ena               = ($urandom_range(0, 9) < 8);
      in_a              = 8'($urandom);
      in_b              = 8'($urandom);
      cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_chan   = 3'($urandom_range(0, 7));
      cfg_if.cfg_lut    = 4'($urandom);
      cfg_if.cfg_mode   = 1'($urandom);
      cfg_if.cfg_commit = ($urandom_range(0, 11) == 0);
      tick();
      if (k == 200) do_reset();
    end
    idle_cfg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
